// File: rtl/uart_resp_sched.sv
// Transmit scheduler that shares one UART transmitter between a single-byte responder (A)
// and a 16-bit MSB-first status port (B), with round-robin arbitration and inter-byte gap.
module uart_resp_sched #(
    parameter int GAP_CYCLES   = 0,
    parameter int ABORT_CYCLES = 16'hFFFF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_a,
    input  logic [7:0]  data_a,
    input  logic        req_b,
    input  logic [15:0] data_b,
    output logic        busy_a,
    output logic        busy_b,
    output logic        done_a,
    output logic        done_b,
    output logic [1:0]  ovr,
    output logic        tmo,
    input  logic        clr_err,
    output logic        trmt,
    output logic [7:0]  tx_data,
    input  logic        tx_done,
    output logic [2:0]  dbg_state
);
    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        SEND_A  = 3'd1,
        SEND_BH = 3'd2,
        SEND_BL = 3'd3,
        GAP     = 3'd4
    } state_t;

    localparam logic [7:0]  GAP_LAST   = (GAP_CYCLES > 0) ? 8'(GAP_CYCLES - 1) : 8'd0;
    localparam logic [15:0] ABORT_LAST = 16'(ABORT_CYCLES - 1);
    localparam bit          GAP_ZERO   = (GAP_CYCLES == 0);

    state_t      r_state;
    state_t      r_target;
    logic        r_busy_a;
    logic        r_busy_b;
    logic [7:0]  r_data_a;
    logic [15:0] r_data_b;
    logic [7:0]  r_lo;
    logic        r_rr;
    logic        r_trmt;
    logic [7:0]  r_tx_data;
    logic        r_done_a;
    logic        r_done_b;
    logic [1:0]  r_ovr;
    logic        r_tmo;
    logic [7:0]  r_gap_cnt;
    logic [15:0] r_tmo_cnt;

    state_t      w_next;
    logic        w_grant_a;
    logic        w_grant_b;
    logic        w_sending;
    logic        w_timeout;
    logic        w_gap_end;
    logic        w_issue;
    logic [7:0]  w_issue_data;
    logic        w_fin_a;
    logic        w_fin_b;

    // r_rr records the last contested winner (0 = A, 1 = B); the other port wins the next tie.
    always_comb begin
        w_grant_a = 1'b0;
        w_grant_b = 1'b0;
        if (r_state == IDLE) begin
            if (r_busy_a && r_busy_b) begin
                w_grant_a = r_rr;
                w_grant_b = ~r_rr;
            end else begin
                w_grant_a = r_busy_a;
                w_grant_b = r_busy_b;
            end
        end
    end

    assign w_sending = (r_state == SEND_A) || (r_state == SEND_BH) || (r_state == SEND_BL);
    assign w_timeout = w_sending && !tx_done && (r_tmo_cnt == ABORT_LAST);
    assign w_gap_end = (r_state == GAP) && (r_gap_cnt == GAP_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: begin
                if (w_grant_b) begin
                    w_next = SEND_BH;
                end else if (w_grant_a) begin
                    w_next = SEND_A;
                end
            end
            SEND_A, SEND_BL: begin
                if (tx_done) begin
                    w_next = GAP_ZERO ? IDLE : GAP;
                end else if (w_timeout) begin
                    w_next = IDLE;
                end
            end
            SEND_BH: begin
                if (tx_done) begin
                    w_next = GAP_ZERO ? SEND_BL : GAP;
                end else if (w_timeout) begin
                    w_next = IDLE;
                end
            end
            GAP: begin
                if (w_gap_end) begin
                    w_next = r_target;
                end
            end
            default: w_next = IDLE;
        endcase
    end

    // Every entry into a SEND state launches exactly one byte.
    always_comb begin
        w_issue = (w_next != r_state) &&
                  ((w_next == SEND_A) || (w_next == SEND_BH) || (w_next == SEND_BL));
        w_issue_data = r_lo;
        if (w_next == SEND_A) begin
            w_issue_data = r_data_a;
        end else if (w_next == SEND_BH) begin
            w_issue_data = r_data_b[15:8];
        end
        w_fin_a = (r_state == SEND_A) && tx_done;
        w_fin_b = (r_state == SEND_BL) && tx_done;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_target  <= IDLE;
            r_busy_a  <= 1'b0;
            r_busy_b  <= 1'b0;
            r_data_a  <= 8'd0;
            r_data_b  <= 16'd0;
            r_lo      <= 8'd0;
            r_rr      <= 1'b0;
            r_trmt    <= 1'b0;
            r_tx_data <= 8'd0;
            r_done_a  <= 1'b0;
            r_done_b  <= 1'b0;
            r_ovr     <= 2'b00;
            r_tmo     <= 1'b0;
            r_gap_cnt <= 8'd0;
            r_tmo_cnt <= 16'd0;
        end else begin
            r_trmt   <= w_issue;
            r_done_a <= w_fin_a;
            r_done_b <= w_fin_b;
            if (w_issue) begin
                r_tx_data <= w_issue_data;
            end

            // A slot being granted this cycle may be refilled by a simultaneous request.
            if (req_a && (!r_busy_a || w_grant_a)) begin
                r_busy_a <= 1'b1;
                r_data_a <= data_a;
            end else if (w_grant_a) begin
                r_busy_a <= 1'b0;
            end
            if (req_b && (!r_busy_b || w_grant_b)) begin
                r_busy_b <= 1'b1;
                r_data_b <= data_b;
            end else if (w_grant_b) begin
                r_busy_b <= 1'b0;
            end
            if (w_grant_b) begin
                r_lo <= r_data_b[7:0];
            end
            if (r_busy_a && r_busy_b && (r_state == IDLE)) begin
                r_rr <= w_grant_b;
            end

            r_ovr[0] <= (req_a && r_busy_a && !w_grant_a) || (r_ovr[0] && !clr_err);
            r_ovr[1] <= (req_b && r_busy_b && !w_grant_b) || (r_ovr[1] && !clr_err);
            r_tmo    <= w_timeout || (r_tmo && !clr_err);

            if ((w_next == GAP) && (r_state != GAP)) begin
                r_gap_cnt <= 8'd0;
                r_target  <= (r_state == SEND_BH) ? SEND_BL : IDLE;
            end else if (r_state == GAP) begin
                r_gap_cnt <= r_gap_cnt + 8'd1;
            end

            if (w_issue) begin
                r_tmo_cnt <= 16'd0;
            end else if (w_sending) begin
                r_tmo_cnt <= r_tmo_cnt + 16'd1;
            end
        end
    end

    assign busy_a    = r_busy_a;
    assign busy_b    = r_busy_b;
    assign done_a    = r_done_a;
    assign done_b    = r_done_b;
    assign ovr       = r_ovr;
    assign tmo       = r_tmo;
    assign trmt      = r_trmt;
    assign tx_data   = r_tx_data;
    assign dbg_state = r_state;
endmodule
